cbus_axi_bridge: RTL

//  Converts the single CBus transaction stream leaving the CBus arbiter into AXI4 master traffic.

---
 rtl/cbus_axi_bridge_pkg.sv | 32 +++
 rtl/cbus_axi_bridge_if.sv | 73 +++++++
 rtl/cbus_axi_bridge.sv | 110 +++++++++++
 3 files changed

// File: rtl/cbus_axi_bridge_pkg.sv
// cbus_axi_bridge_pkg: CBus request/response bundles and AXI4 constants
// shared by the bridge, its interface and the bench.
package cbus_axi_bridge_pkg;

  typedef logic [2:0] msize_t;
  typedef logic [3:0] mlen_t;
  typedef logic [7:0] axi_len_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [31:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    mlen_t       len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

  function automatic axi_len_t to_axi_len(mlen_t l);
    return {4'b0, l};
  endfunction

endpackage

// File: rtl/cbus_axi_bridge_if.sv
// cbus_axi_bridge_if: CBus stream plus AXI4 channels of one bridge.
// master = bridge side, slave = arbiter/interconnect side.
interface cbus_axi_bridge_if #(
  parameter int ID_W = 4
);
  import cbus_axi_bridge_pkg::*;

  cbus_req_t  creq;
  cbus_resp_t cresp;

  logic [31:0]     araddr;
  axi_len_t        arlen;
  msize_t          arsize;
  logic [1:0]      arburst;
  logic [ID_W-1:0] arid;
  logic            arvalid;
  logic            arready;

  logic [63:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic [ID_W-1:0] rid;
  logic            rvalid;
  logic            rready;

  logic [31:0]     awaddr;
  axi_len_t        awlen;
  msize_t          awsize;
  logic [1:0]      awburst;
  logic [ID_W-1:0] awid;
  logic            awvalid;
  logic            awready;

  logic [63:0]     wdata;
  logic [7:0]      wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;

  logic [1:0]      bresp;
  logic [ID_W-1:0] bid;
  logic            bvalid;
  logic            bready;

  modport master (
    input  creq, output cresp,
    output araddr, arlen, arsize, arburst, arid, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rid, rvalid,
    output rready,
    output awaddr, awlen, awsize, awburst, awid, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bid, bvalid,
    output bready
  );

  modport slave (
    output creq, input cresp,
    input  araddr, arlen, arsize, arburst, arid, arvalid,
    output arready,
    output rdata, rresp, rlast, rid, rvalid,
    input  rready,
    input  awaddr, awlen, awsize, awburst, awid, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bid, bvalid,
    input  bready
  );

endinterface

// File: rtl/cbus_axi_bridge.sv
// cbus_axi_bridge: turns the arbitrated CBus stream into AXI4 bursts,
// one AR/R or AW/W/B transaction at a time.
module cbus_axi_bridge
  import cbus_axi_bridge_pkg::*;
#(
  parameter int AXI_ID_WIDTH = 4,
  parameter int AXI_ID       = 0
) (
  input  logic clk,
  input  logic reset,
  cbus_axi_bridge_if.master bus,
  output logic axi_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_AR, S_R, S_AW, S_W, S_B
  } state_t;

  state_t      r_state;
  logic [31:0] r_addr;
  msize_t      r_size;
  mlen_t       r_len;
  mlen_t       r_cnt;
  logic        r_err;

  logic w_cnt_last;
  logic w_rbeat;
  logic w_wbeat;
  logic w_bbeat;
  logic w_rd_bad;
  logic w_wr_bad;
  logic w_unused;

  assign w_cnt_last = (r_cnt == r_len);
  assign w_rbeat = (r_state == S_R) & bus.rvalid;
  assign w_wbeat = (r_state == S_W) & bus.wready;
  assign w_bbeat = (r_state == S_B) & bus.bvalid;
  assign w_rd_bad = w_rbeat & (bus.rresp != AXI_RESP_OKAY);
  assign w_wr_bad = w_bbeat & (bus.bresp != AXI_RESP_OKAY);

  // IDs and rlast are never inspected: termination is by beat count
  assign w_unused = ^{bus.rid, bus.bid, bus.rlast};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_size  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_rd_bad | w_wr_bad)
        r_err <= 1'b1;
      unique case (r_state)
        S_IDLE: if (bus.creq.valid) begin
          r_addr  <= bus.creq.addr;
          r_size  <= bus.creq.size;
          r_len   <= bus.creq.len;
          r_cnt   <= '0;
          r_state <= bus.creq.is_write ? S_AW : S_AR;
        end
        S_AR: if (bus.arready) r_state <= S_R;
        S_R: if (bus.rvalid) begin
          if (w_cnt_last) r_state <= S_IDLE;
          else            r_cnt   <= r_cnt + 4'd1;
        end
        S_AW: if (bus.awready) r_state <= S_W;
        S_W: if (bus.wready) begin
          if (w_cnt_last) r_state <= S_B;
          else            r_cnt   <= r_cnt + 4'd1;
        end
        S_B: if (bus.bvalid) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.araddr  = r_addr;
  assign bus.arlen   = to_axi_len(r_len);
  assign bus.arsize  = r_size;
  assign bus.arburst = AXI_BURST_INCR;
  assign bus.arid    = AXI_ID_WIDTH'(AXI_ID);
  assign bus.arvalid = (r_state == S_AR);
  assign bus.rready  = (r_state == S_R);

  assign bus.awaddr  = r_addr;
  assign bus.awlen   = to_axi_len(r_len);
  assign bus.awsize  = r_size;
  assign bus.awburst = AXI_BURST_INCR;
  assign bus.awid    = AXI_ID_WIDTH'(AXI_ID);
  assign bus.awvalid = (r_state == S_AW);

  assign bus.wvalid = (r_state == S_W);
  assign bus.wdata  = bus.wvalid ? bus.creq.data : '0;
  assign bus.wstrb  = bus.wvalid ? bus.creq.strobe : '0;
  assign bus.wlast  = bus.wvalid & w_cnt_last;
  assign bus.bready = (r_state == S_B);

  // final W beat is acknowledged to CBus only once B returns
  always_comb begin
    bus.cresp = '0;
    bus.cresp.ready = w_rbeat | (w_wbeat & ~w_cnt_last) | w_bbeat;
    bus.cresp.last  = (w_rbeat & w_cnt_last) | w_bbeat;
    bus.cresp.data  = (r_state == S_R) ? bus.rdata : '0;
  end

  assign axi_err = r_err;

endmodule
